if_id_fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the 8-bit pipelined core; sits directly upstream of the control unit and feeds it opcode/ra.
- Owns the PC, the reset/interrupt vector loads and capture of the second byte of 2-byte instructions.
- Obeys the control unit's PC_Write_En / IF_ID_Write_En / Inject_Bubble / Inject_Int and the EX-stage branch redirect.

---
 rtl/if_id_fetch_stage_if.sv | 16 +
 rtl/if_id_fetch_stage.sv | 209 ++++++++++++++++++++
 tb/tb_if_id_fetch_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/if_id_fetch_stage_if.sv
// Instruction memory bus between the fetch stage and instruction memory.
// master: drives imem_addr, receives imem_data (async read).
interface if_id_fetch_stage_if;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;

  modport master (
    output imem_addr,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    output imem_data
  );
endinterface

// File: rtl/if_id_fetch_stage.sv
// IF stage + IF/ID register: owns PC, reset/interrupt vector loads,
// trailing immediate capture; optional FETCH_PERF_CNT_EN fetch counter.
// Ports: clk, rst (sync, high); imem (master bus); control-unit
// enables; EX redirect; id_* IF/ID outputs; perf_fetch_cnt (optional).
module if_id_fetch_stage #(
  parameter logic [7:0] RESET_VEC_ADDR = 8'h00,
  parameter logic [7:0] INT_VEC_ADDR   = 8'h01,
  parameter logic [3:0] TWO_BYTE_OP    = 4'hC
) (
  input  logic       clk,
  input  logic       rst,
  if_id_fetch_stage_if.master imem,
  input  logic       pc_write_en,
  input  logic       if_id_write_en,
  input  logic       inject_bubble,
  input  logic       inject_int,
  input  logic       branch_taken,
  input  logic [7:0] branch_target,
  output logic [3:0] id_opcode,
  output logic [1:0] id_ra,
  output logic [1:0] id_rb,
  output logic [7:0] id_imm,
  output logic       id_imm_valid,
  output logic [7:0] id_pc_plus1,
  output logic       id_valid,
  output logic       id_int
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] perf_fetch_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RST_VEC,
    S_RUN,
    S_IMM,
    S_INT_VEC
  } state_t;

  state_t     r_state;
  state_t     w_state_n;
  logic [7:0] r_pc;
  logic [7:0] w_pc_n;
  logic [7:0] r_instr;
  logic [7:0] w_instr_n;
  logic [7:0] r_imm;
  logic [7:0] w_imm_n;
  logic       r_imm_valid;
  logic       w_imm_valid_n;
  logic [7:0] r_pc1;
  logic [7:0] w_pc1_n;
  logic       r_valid;
  logic       w_valid_n;
  logic       r_int;
  logic       w_int_n;
  logic       r_pend;
  logic       w_pend_n;
  logic       w_fetch;
  logic       w_clr;
  logic [7:0] w_addr;

  assign imem.imem_addr = w_addr;

  always_comb begin
    w_state_n     = r_state;
    w_pc_n        = r_pc;
    w_instr_n     = r_instr;
    w_imm_n       = r_imm;
    w_imm_valid_n = r_imm_valid;
    w_pc1_n       = r_pc1;
    w_valid_n     = r_valid;
    w_int_n       = r_int;
    w_pend_n      = r_pend;
    w_fetch       = 1'b0;
    w_clr         = 1'b0;
    w_addr        = r_pc;

    unique case (r_state)
      S_RST_VEC: begin
        w_addr    = RESET_VEC_ADDR;
        w_pc_n    = imem.imem_data;
        w_state_n = S_RUN;
        w_clr     = 1'b1;
        w_pend_n  = r_pend | inject_int;
      end
      S_RUN: begin
        if (branch_taken) begin
          w_pc_n   = branch_target;
          w_clr    = 1'b1;
          // a request racing the redirect is held, not lost
          w_pend_n = r_pend | inject_int;
        end else if (inject_int || r_pend) begin
          // phantom: return address is the un-issued instruction
          w_instr_n     = 8'h00;
          w_imm_n       = 8'h00;
          w_imm_valid_n = 1'b0;
          w_pc1_n       = r_pc;
          w_valid_n     = 1'b1;
          w_int_n       = 1'b1;
          w_pend_n      = 1'b0;
          w_state_n     = S_INT_VEC;
        end else begin
          if (pc_write_en) begin
            w_pc_n = r_pc + 8'd1;
          end
          if (inject_bubble) begin
            w_clr = 1'b1;
          end else if (if_id_write_en) begin
            w_instr_n     = imem.imem_data;
            w_imm_n       = 8'h00;
            w_imm_valid_n = 1'b0;
            w_pc1_n       = r_pc + 8'd1;
            w_valid_n     = 1'b1;
            w_int_n       = 1'b0;
            w_fetch       = 1'b1;
            if (imem.imem_data[7:4] == TWO_BYTE_OP
                && pc_write_en) begin
              w_state_n = S_IMM;
            end
          end
        end
      end
      S_IMM: begin
        w_pend_n = r_pend | inject_int;
        if (branch_taken) begin
          w_pc_n    = branch_target;
          w_clr     = 1'b1;
          w_state_n = S_RUN;
        end else begin
          w_imm_n       = imem.imem_data;
          w_imm_valid_n = 1'b1;
          w_pc_n        = r_pc + 8'd1;
          w_pc1_n       = r_pc + 8'd1;
          w_state_n     = S_RUN;
        end
      end
      S_INT_VEC: begin
        w_addr    = INT_VEC_ADDR;
        w_pc_n    = imem.imem_data;
        w_clr     = 1'b1;
        w_state_n = S_RUN;
        w_pend_n  = r_pend | inject_int;
      end
      default: begin
        w_state_n = S_RUN;
      end
    endcase

    if (w_clr) begin
      w_instr_n     = 8'h00;
      w_imm_n       = 8'h00;
      w_imm_valid_n = 1'b0;
      w_pc1_n       = 8'h00;
      w_valid_n     = 1'b0;
      w_int_n       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RST_VEC;
      r_pc        <= 8'h00;
      r_pend      <= 1'b0;
      r_instr     <= 8'h00;
      r_imm       <= 8'h00;
      r_imm_valid <= 1'b0;
      r_pc1       <= 8'h00;
      r_valid     <= 1'b0;
      r_int       <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_pc        <= w_pc_n;
      r_pend      <= w_pend_n;
      r_instr     <= w_instr_n;
      r_imm       <= w_imm_n;
      r_imm_valid <= w_imm_valid_n;
      r_pc1       <= w_pc1_n;
      r_valid     <= w_valid_n;
      r_int       <= w_int_n;
    end
  end

  assign id_opcode    = r_instr[7:4];
  assign id_ra        = r_instr[3:2];
  assign id_rb        = r_instr[1:0];
  assign id_imm       = r_imm;
  assign id_imm_valid = r_imm_valid;
  assign id_pc_plus1  = r_pc1;
  assign id_valid     = r_valid;
  assign id_int       = r_int;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_perf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf <= 16'h0000;
    end else if (w_fetch && r_perf != 16'hFFFF) begin
      r_perf <= r_perf + 16'd1;
    end
  end

  assign perf_fetch_cnt = r_perf;
`else
  logic w_fetch_unused;
  assign w_fetch_unused = w_fetch;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed self-checking bench for if_id_fetch_stage.
// Drives inputs on negedge, samples outputs on the following negedge.
module tb_if_id_fetch_stage;

  logic       clk;
  logic       rst;
  logic       pc_write_en;
  logic       if_id_write_en;
  logic       inject_bubble;
  logic       inject_int;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic [3:0] id_opcode;
  logic [1:0] id_ra;
  logic [1:0] id_rb;
  logic [7:0] id_imm;
  logic       id_imm_valid;
  logic [7:0] id_pc_plus1;
  logic       id_valid;
  logic       id_int;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt;
`endif

  logic [7:0] mem [256];
  int n_chk;
  int n_fail;

  if_id_fetch_stage_if u_if ();
  assign u_if.imem_data = mem[u_if.imem_addr];

  if_id_fetch_stage u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (u_if.master),
    .pc_write_en    (pc_write_en),
    .if_id_write_en (if_id_write_en),
    .inject_bubble  (inject_bubble),
    .inject_int     (inject_int),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .id_opcode      (id_opcode),
    .id_ra          (id_ra),
    .id_rb          (id_rb),
    .id_imm         (id_imm),
    .id_imm_valid   (id_imm_valid),
    .id_pc_plus1    (id_pc_plus1),
    .id_valid       (id_valid),
    .id_int         (id_int)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h20;
    mem[8'h01] = 8'h80;
    mem[8'h20] = 8'h24;
    mem[8'h21] = 8'hC4;
    mem[8'h22] = 8'h5A;
    mem[8'h80] = 8'hC4;
    mem[8'h81] = 8'h77;
    mem[8'hFF] = 8'h10;

    rst = 1'b1;
    pc_write_en = 1'b1;
    if_id_write_en = 1'b1;
    inject_bubble = 1'b0;
    inject_int = 1'b0;
    branch_taken = 1'b0;
    branch_target = 8'h00;
    step();
    step();
    chk("rst_addr", 16'(u_if.imem_addr), 16'h00);
    chk("rst_valid", 16'(id_valid), 16'h0);
    chk("rst_pc1", 16'(id_pc_plus1), 16'h00);
    chk("rst_op", 16'(id_opcode), 16'h0);
    rst = 1'b0;

    step();
    chk("vec_addr", 16'(u_if.imem_addr), 16'h20);
    chk("vec_valid", 16'(id_valid), 16'h0);

    step();
    chk("alu_op", 16'(id_opcode), 16'h2);
    chk("alu_ra", 16'(id_ra), 16'h1);
    chk("alu_rb", 16'(id_rb), 16'h0);
    chk("alu_pc1", 16'(id_pc_plus1), 16'h21);
    chk("alu_valid", 16'(id_valid), 16'h1);
    chk("alu_addr", 16'(u_if.imem_addr), 16'h21);

    step();
    chk("ldm_op", 16'(id_opcode), 16'hC);
    chk("ldm_addr", 16'(u_if.imem_addr), 16'h22);
    if_id_write_en = 1'b0;
    step();
    chk("imm_op", 16'(id_opcode), 16'hC);
    chk("imm_val", 16'(id_imm), 16'h5A);
    chk("imm_vld", 16'(id_imm_valid), 16'h1);
    chk("imm_addr", 16'(u_if.imem_addr), 16'h23);
    chk("imm_pc1", 16'(id_pc_plus1), 16'h23);

    pc_write_en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("stall_addr", 16'(u_if.imem_addr), 16'h23);
    chk("stall_op", 16'(id_opcode), 16'hC);
    chk("stall_imm", 16'(id_imm), 16'h5A);
    chk("stall_pc1", 16'(id_pc_plus1), 16'h23);
    pc_write_en = 1'b1;
    if_id_write_en = 1'b1;

    branch_taken = 1'b1;
    branch_target = 8'h30;
    step();
    branch_taken = 1'b0;
    chk("br30_addr", 16'(u_if.imem_addr), 16'h30);
    chk("br30_valid", 16'(id_valid), 16'h0);

    inject_int = 1'b1;
    step();
    inject_int = 1'b0;
    chk("int_flag", 16'(id_int), 16'h1);
    chk("int_valid", 16'(id_valid), 16'h1);
    chk("int_pc1", 16'(id_pc_plus1), 16'h30);
    chk("int_addr", 16'(u_if.imem_addr), 16'h01);
    step();
    chk("isr_addr", 16'(u_if.imem_addr), 16'h80);
    chk("isr_valid", 16'(id_valid), 16'h0);
    chk("isr_int", 16'(id_int), 16'h0);

    step();
    chk("ldm2_op", 16'(id_opcode), 16'hC);
    chk("ldm2_addr", 16'(u_if.imem_addr), 16'h81);
    inject_int = 1'b1;
    step();
    inject_int = 1'b0;
    chk("imm2_val", 16'(id_imm), 16'h77);
    chk("imm2_int", 16'(id_int), 16'h0);
    chk("imm2_addr", 16'(u_if.imem_addr), 16'h82);
    step();
    chk("pend_int", 16'(id_int), 16'h1);
    chk("pend_pc1", 16'(id_pc_plus1), 16'h82);
    chk("pend_addr", 16'(u_if.imem_addr), 16'h01);
    step();
    chk("pend_isr", 16'(u_if.imem_addr), 16'h80);

    branch_taken = 1'b1;
    branch_target = 8'h44;
    inject_int = 1'b1;
    step();
    branch_taken = 1'b0;
    inject_int = 1'b0;
    chk("brp_addr", 16'(u_if.imem_addr), 16'h44);
    chk("brp_valid", 16'(id_valid), 16'h0);
    chk("brp_int", 16'(id_int), 16'h0);
    step();
    chk("brp_int2", 16'(id_int), 16'h1);
    chk("brp_pc1", 16'(id_pc_plus1), 16'h44);
    step();
    chk("brp_isr", 16'(u_if.imem_addr), 16'h80);

    branch_taken = 1'b1;
    branch_target = 8'hFF;
    step();
    branch_taken = 1'b0;
    chk("wrap_pre", 16'(u_if.imem_addr), 16'hFF);
    step();
    chk("wrap_op", 16'(id_opcode), 16'h1);
    chk("wrap_pc1", 16'(id_pc_plus1), 16'h00);
    chk("wrap_addr", 16'(u_if.imem_addr), 16'h00);

    inject_bubble = 1'b1;
    step();
    inject_bubble = 1'b0;
    chk("bub_valid", 16'(id_valid), 16'h0);
    chk("bub_op", 16'(id_opcode), 16'h0);
    chk("bub_addr", 16'(u_if.imem_addr), 16'h01);

`ifdef FETCH_PERF_CNT_EN
    chk("perf_cnt", perf_fetch_cnt, 16'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
